// File: rtl/bin_acc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bin_acc_pkg
// Purpose  : Shared definitions for the binary XNOR accelerator stages:
//            default SRAM geometry, the end-of-stream marker, the one-hot
//            pooling FSM encoding and the legal-header check.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package bin_acc_pkg;

  // Geometry shared by the convolution and pooling stages.
  localparam int          ADDR_W_DEF    = 12;
  localparam int          DATA_W_DEF    = 16;
  localparam logic [15:0] TERM_WORD_DEF = 16'h00FF;

  // One-hot state encoding for the pooling stage.
  typedef enum logic [6:0] {
    ST_IDLE      = 7'b000_0001,
    ST_HDR_RD    = 7'b000_0010,
    ST_HDR_CHK   = 7'b000_0100,
    ST_ROW_RD    = 7'b000_1000,
    ST_ROW_FLUSH = 7'b001_0000,
    ST_TERM_WR   = 7'b010_0000,
    ST_DONE      = 7'b100_0000
  } pool_state_t;

  // A map header is legal when it is even and lies in 2..max_m. With a
  // 16-bit word and max_m = 16 this also forces bits [15:5] to zero.
  function automatic logic hdr_is_legal(input logic [31:0] hdr, input int max_m);
    return (hdr >= 32'd2) && (hdr <= 32'(max_m)) && (hdr[0] == 1'b0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pool_row_reduce.sv
`default_nettype none
// ============================================================================
// Module   : pool_row_reduce
// Purpose  : Combinational 2x2 binary max-pool of one row pair. The two rows
//            are ORed, then adjacent column pairs are ORed into one pooled
//            bit each. Pooled bits at or above half_m are forced to zero.
// Ports    : even_row [DATA_W] - row 2r of the map
//            odd_row  [DATA_W] - row 2r+1 of the map
//            half_m   [HALF_W] - pooled map width (M/2)
//            pooled   [DATA_W] - pooled output row, upper half always zero
// Revision : 1.0 - initial release
// ============================================================================
module pool_row_reduce #(
  parameter int DATA_W = 16,
  parameter int HALF_W = 4
) (
  input  logic [DATA_W-1:0] even_row,
  input  logic [DATA_W-1:0] odd_row,
  input  logic [HALF_W-1:0] half_m,
  output logic [DATA_W-1:0] pooled
);

  logic [DATA_W-1:0] w_or;

  assign w_or = even_row | odd_row;

  generate
    for (genvar k = 0; k < DATA_W / 2; k++) begin : g_pair
      localparam logic [HALF_W-1:0] c_k = HALF_W'(k);
      // Columns beyond the map width may hold stale data; mask them here.
      assign pooled[k] = (w_or[2*k] | w_or[2*k+1]) & (c_k < half_m);
    end
    for (genvar k = DATA_W / 2; k < DATA_W; k++) begin : g_upper
      assign pooled[k] = 1'b0;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/bin_maxpool_stage.sv
`default_nettype none
// ============================================================================
// Module   : bin_maxpool_stage
// Purpose  : Streams feature maps out of the convolution SRAM, applies 2x2
//            stride-2 binary max-pooling (bitwise OR) and writes the pooled
//            maps, each prefixed by its halved header, to the pool SRAM.
//            The stream ends with TERM_WORD; an illegal header sets the
//            sticky error flag and ends the stream.
// Ports    : clk, reset_b (async, active-low)
//            pool_run                 - start pulse, honoured only when idle
//            pool_busy                - run in progress
//            pool_err                 - sticky bad-header flag
//            pool_sram_read_address   - registered read address
//            sram_pool_read_data      - read data, one cycle after address
//            pool_sram_write_address  - registered write address
//            pool_sram_write_data     - registered write data
//            pool_sram_write_enable   - registered write strobe
// Revision : 1.0 - initial release
// ============================================================================
module bin_maxpool_stage
  import bin_acc_pkg::*;
#(
  parameter int                ADDR_W    = ADDR_W_DEF,
  parameter int                DATA_W    = DATA_W_DEF,
  parameter logic [DATA_W-1:0] TERM_WORD = DATA_W'(TERM_WORD_DEF)
) (
  input  logic              clk,
  input  logic              reset_b,
  input  logic              pool_run,
  output logic              pool_busy,
  output logic              pool_err,
  output logic [ADDR_W-1:0] pool_sram_read_address,
  input  logic [DATA_W-1:0] sram_pool_read_data,
  output logic [ADDR_W-1:0] pool_sram_write_address,
  output logic [DATA_W-1:0] pool_sram_write_data,
  output logic              pool_sram_write_enable
);

  localparam int c_cnt_w  = $clog2(DATA_W + 1);
  localparam int c_half_w = c_cnt_w - 1;

  pool_state_t         r_state, w_state;
  logic [ADDR_W-1:0]   r_rd_addr, w_rd_addr;
  logic [ADDR_W-1:0]   r_wr_addr, w_wr_addr;
  logic [ADDR_W-1:0]   r_wr_ptr, w_wr_ptr;     // next free pool SRAM slot
  logic [DATA_W-1:0]   r_wr_data, w_wr_data;
  logic                r_wr_en, w_wr_en;
  logic                r_busy, w_busy;
  logic                r_err, w_err;
  logic [c_cnt_w-1:0]  r_m, w_m;               // latched map width M
  logic [c_cnt_w-1:0]  r_row, w_row;           // row whose data is on the bus
  logic [DATA_W-1:0]   r_pair, w_pair;         // held even row
  logic                w_do_write;
  logic [DATA_W-1:0]   w_write_word;
  logic [DATA_W-1:0]   w_pooled;
  logic                w_last_row;

  assign w_last_row = (r_row == (r_m - c_cnt_w'(1)));

  pool_row_reduce #(
    .DATA_W (DATA_W),
    .HALF_W (c_half_w)
  ) u_row_reduce (
    .even_row (r_pair),
    .odd_row  (sram_pool_read_data),
    .half_m   (r_m[c_cnt_w-1:1]),
    .pooled   (w_pooled)
  );

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      r_state   <= ST_IDLE;
      r_rd_addr <= '0;
      r_wr_addr <= '0;
      r_wr_ptr  <= '0;
      r_wr_data <= '0;
      r_wr_en   <= 1'b0;
      r_busy    <= 1'b0;
      r_err     <= 1'b0;
      r_m       <= '0;
      r_row     <= '0;
      r_pair    <= '0;
    end else begin
      r_state   <= w_state;
      r_rd_addr <= w_rd_addr;
      r_wr_addr <= w_wr_addr;
      r_wr_ptr  <= w_wr_ptr;
      r_wr_data <= w_wr_data;
      r_wr_en   <= w_wr_en;
      r_busy    <= w_busy;
      r_err     <= w_err;
      r_m       <= w_m;
      r_row     <= w_row;
      r_pair    <= w_pair;
    end
  end

  // Read addressing runs one word ahead of the data bus: the first row
  // address is issued while the header is still being fetched, so row r's
  // data is on the bus during ROW_RD cycle r. The last pooled write is then
  // issued on the final ROW_RD edge and lands in ROW_FLUSH, and the next
  // header address is already presented before HDR_RD.
  always_comb begin
    w_state      = r_state;
    w_rd_addr    = r_rd_addr;
    w_wr_addr    = r_wr_addr;
    w_wr_ptr     = r_wr_ptr;
    w_wr_data    = r_wr_data;
    w_wr_en      = 1'b0;
    w_busy       = r_busy;
    w_err        = r_err;
    w_m          = r_m;
    w_row        = r_row;
    w_pair       = r_pair;
    w_do_write   = 1'b0;
    w_write_word = '0;

    unique case (r_state)
      ST_IDLE: begin
        if (pool_run) begin
          w_rd_addr = '0;
          w_wr_addr = '0;
          w_wr_ptr  = '0;
          w_err     = 1'b0;
          w_busy    = 1'b1;
          w_state   = ST_HDR_RD;
        end
      end
      ST_HDR_RD: begin
        w_rd_addr = r_rd_addr + 1'b1;
        w_state   = ST_HDR_CHK;
      end
      ST_HDR_CHK: begin
        if (sram_pool_read_data == TERM_WORD) begin
          w_do_write   = 1'b1;
          w_write_word = TERM_WORD;
          w_state      = ST_TERM_WR;
        end else if (hdr_is_legal(32'(sram_pool_read_data), DATA_W)) begin
          w_m          = sram_pool_read_data[c_cnt_w-1:0];
          w_do_write   = 1'b1;
          w_write_word = sram_pool_read_data >> 1;
          w_rd_addr    = r_rd_addr + 1'b1;
          w_row        = '0;
          w_state      = ST_ROW_RD;
        end else begin
          w_err        = 1'b1;
          w_do_write   = 1'b1;
          w_write_word = TERM_WORD;
          w_state      = ST_TERM_WR;
        end
      end
      ST_ROW_RD: begin
        if (!r_row[0]) begin
          w_pair = sram_pool_read_data;
        end else begin
          w_do_write   = 1'b1;
          w_write_word = w_pooled;
        end
        if (w_last_row) begin
          w_state = ST_ROW_FLUSH;
        end else begin
          w_rd_addr = r_rd_addr + 1'b1;
          w_row     = r_row + 1'b1;
        end
      end
      ST_ROW_FLUSH: begin
        w_state = ST_HDR_RD;
      end
      ST_TERM_WR: begin
        // The terminator strobe is active in this cycle.
        w_busy  = 1'b0;
        w_state = ST_DONE;
      end
      ST_DONE: begin
        w_rd_addr = '0;
        w_state   = ST_IDLE;
      end
      default: begin
        w_state = ST_IDLE;
      end
    endcase

    // Writes go to the next free slot; the pointer advances only on a write.
    if (w_do_write) begin
      w_wr_en   = 1'b1;
      w_wr_addr = r_wr_ptr;
      w_wr_ptr  = r_wr_ptr + 1'b1;
      w_wr_data = w_write_word;
    end
  end

  assign pool_busy               = r_busy;
  assign pool_err                = r_err;
  assign pool_sram_read_address  = r_rd_addr;
  assign pool_sram_write_address = r_wr_addr;
  assign pool_sram_write_data    = r_wr_data;
  assign pool_sram_write_enable  = r_wr_en;

endmodule
`default_nettype wire

// File: tb/tb_bin_maxpool_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_bin_maxpool_stage
// Purpose  : Directed, table-driven bench for bin_maxpool_stage with a
//            behavioural one-cycle-latency read SRAM and a write log.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bin_maxpool_stage;

  localparam int AW = 12;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset_b = 1'b0;
  logic          pool_run = 1'b0;
  logic          pool_busy;
  logic          pool_err;
  logic [AW-1:0] raddr;
  logic [DW-1:0] rdata = '0;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic          wen;

  logic [DW-1:0] mem [4096];

  logic [AW-1:0] wa_q[$];
  logic [DW-1:0] wd_q[$];
  int            wt_q[$];
  logic [AW-1:0] ea_q[$];
  logic [DW-1:0] ed_q[$];

  int cyc = 0;
  int idle_wr = 0;
  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    int          m;
    logic [15:0] ev;
    logic [15:0] od;
    logic [15:0] exp;
  } vec_t;
  vec_t vecs[8];

  always #5 clk = ~clk;

  bin_maxpool_stage dut (
    .clk                     (clk),
    .reset_b                 (reset_b),
    .pool_run                (pool_run),
    .pool_busy               (pool_busy),
    .pool_err                (pool_err),
    .pool_sram_read_address  (raddr),
    .sram_pool_read_data     (rdata),
    .pool_sram_write_address (waddr),
    .pool_sram_write_data    (wdata),
    .pool_sram_write_enable  (wen)
  );

  always @(posedge clk) begin
    rdata <= mem[raddr];
    cyc   <= cyc + 1;
  end

  always @(negedge clk) begin
    if (wen) begin
      wa_q.push_back(waddr);
      wd_q.push_back(wdata);
      wt_q.push_back(cyc);
      if (!pool_busy) idle_wr++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic mem_clear();
    for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
  endtask

  task automatic exp_clear();
    ea_q.delete();
    ed_q.delete();
  endtask

  task automatic exp_w(input int a, input logic [15:0] d);
    ea_q.push_back(AW'(a));
    ed_q.push_back(d);
  endtask

  task automatic run(input bit hold, output int t0, output int tf);
    bit ok;
    wa_q.delete();
    wd_q.delete();
    wt_q.delete();
    idle_wr = 0;
    @(negedge clk);
    pool_run = 1'b1;
    t0 = cyc;
    @(negedge clk);
    if (!hold) pool_run = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (!pool_busy) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    pool_run = 1'b0;
    tf = cyc;
    chk("busy falls in time", 32'(ok), 32'd1);
    repeat (5) @(negedge clk);
  endtask

  task automatic check_writes(input string tag);
    chk($sformatf("%s write count", tag), wa_q.size(), ea_q.size());
    for (int i = 0; i < ea_q.size() && i < wa_q.size(); i++) begin
      chk($sformatf("%s addr[%0d]", tag, i), 32'(wa_q[i]), 32'(ea_q[i]));
      chk($sformatf("%s data[%0d]", tag, i), 32'(wd_q[i]), 32'(ed_q[i]));
    end
    chk($sformatf("%s idle writes", tag), idle_wr, 0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, " busy"}, 32'(pool_busy), 0);
    chk({tag, " err"}, 32'(pool_err), 0);
    chk({tag, " raddr"}, 32'(raddr), 0);
    chk({tag, " waddr"}, 32'(waddr), 0);
    chk({tag, " wdata"}, 32'(wdata), 0);
    chk({tag, " wen"}, 32'(wen), 0);
  endtask

  task automatic load_m8();
    mem_clear();
    mem[0] = 16'd8;
    mem[1] = 16'h0081;
    mem[9] = 16'h00FF;
    exp_clear();
    exp_w(0, 16'h0004);
    exp_w(1, 16'h0009);
    for (int a = 2; a <= 4; a++) exp_w(a, 16'h0000);
    exp_w(5, 16'h00FF);
  endtask

  initial begin
    int t0, tf, n;
    logic [15:0] bad_hdr [4];

    vecs[0] = '{2,  16'h0001, 16'h0002, 16'h0001};
    vecs[1] = '{2,  16'hFFFC, 16'h0000, 16'h0000};
    vecs[2] = '{4,  16'h000C, 16'h0000, 16'h0002};
    vecs[3] = '{6,  16'hFFFF, 16'h0000, 16'h0007};
    vecs[4] = '{14, 16'hC000, 16'h2000, 16'h0040};
    vecs[5] = '{16, 16'h8000, 16'h0001, 16'h0081};
    vecs[6] = '{16, 16'h0000, 16'h5555, 16'h00FF};
    vecs[7] = '{8,  16'h0100, 16'h0000, 16'h0000};
    bad_hdr[0] = 16'h0007;
    bad_hdr[1] = 16'h0000;
    bad_hdr[2] = 16'h0012;
    bad_hdr[3] = 16'h0102;

    mem_clear();
    repeat (2) @(negedge clk);
    check_zero("reset");
    reset_b = 1'b1;
    repeat (2) @(negedge clk);

    // Single M=8 map.
    load_m8();
    run(1'b0, t0, tf);
    check_writes("m8");
    chk("m8 first write latency", (wt_q.size() > 0) ? wt_q[0] - t0 : -1, 3);
    chk("m8 busy fall", tf - ((wt_q.size() > 0) ? wt_q[wt_q.size()-1] : 0), 1);
    chk("m8 err", 32'(pool_err), 0);

    // Table of single-row-pair maps.
    foreach (vecs[v]) begin
      mem_clear();
      mem[0] = 16'(vecs[v].m);
      mem[1] = vecs[v].ev;
      mem[2] = vecs[v].od;
      mem[vecs[v].m + 1] = 16'h00FF;
      exp_clear();
      exp_w(0, 16'(vecs[v].m / 2));
      exp_w(1, vecs[v].exp);
      for (int a = 2; a <= vecs[v].m / 2; a++) exp_w(a, 16'h0000);
      exp_w(vecs[v].m / 2 + 1, 16'h00FF);
      run(1'b0, t0, tf);
      check_writes($sformatf("vec%0d", v));
    end

    // Two back-to-back maps.
    mem_clear();
    mem[0] = 16'd10;
    for (int r = 1; r <= 10; r++) mem[r] = 16'h03FF;
    mem[11] = 16'd16;
    for (int r = 0; r < 16; r++) mem[12 + r] = r[0] ? 16'h5555 : 16'hAAAA;
    mem[28] = 16'h00FF;
    exp_clear();
    exp_w(0, 16'h0005);
    for (int a = 1; a <= 5; a++) exp_w(a, 16'h001F);
    exp_w(6, 16'h0008);
    for (int a = 7; a <= 14; a++) exp_w(a, 16'h00FF);
    exp_w(15, 16'h00FF);
    run(1'b0, t0, tf);
    check_writes("two maps");

    // Terminator only.
    mem_clear();
    mem[0] = 16'h00FF;
    exp_clear();
    exp_w(0, 16'h00FF);
    run(1'b0, t0, tf);
    check_writes("term only");
    chk("term only err", 32'(pool_err), 0);
    chk("term only busy within 4", 32'((tf - t0) <= 4), 1);

    // Illegal headers.
    foreach (bad_hdr[b]) begin
      mem_clear();
      mem[0] = bad_hdr[b];
      mem[1] = 16'h00FF;
      exp_clear();
      exp_w(0, 16'h00FF);
      run(1'b0, t0, tf);
      check_writes($sformatf("bad hdr %0h", bad_hdr[b]));
      chk($sformatf("bad hdr %0h err", bad_hdr[b]), 32'(pool_err), 1);
    end
    load_m8();
    run(1'b0, t0, tf);
    check_writes("after err");
    chk("err cleared", 32'(pool_err), 0);

    // pool_run held high for the whole run.
    load_m8();
    run(1'b1, t0, tf);
    check_writes("held run");
    chk("held run idle afterwards", 32'(pool_busy), 0);

    // Reset mid-map after three row reads.
    load_m8();
    wa_q.delete();
    wd_q.delete();
    wt_q.delete();
    @(negedge clk);
    pool_run = 1'b1;
    @(negedge clk);
    pool_run = 1'b0;
    repeat (4) @(negedge clk);
    chk("mid busy", 32'(pool_busy), 1);
    reset_b = 1'b0;
    #1;
    check_zero("mid reset");
    n = wa_q.size();
    repeat (3) @(negedge clk);
    chk("no writes in reset", wa_q.size(), n);
    reset_b = 1'b1;
    @(negedge clk);
    run(1'b0, t0, tf);
    check_writes("after reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bin_maxpool_stage.md
Name: bin_maxpool_stage

Overview:
- Downstream stage of the binary XNOR-convolution accelerator.
- Reads the convolution output SRAM, applies 2x2 stride-2 binary max-pooling to each feature map, and writes pooled maps to the pool SRAM.
- Pooling is a bitwise OR of each 2x2 window.
- Input layout per map: header word M (map width = height), then M row words, bit j = column j. The stream ends with terminator word 16'h00FF.
- Output uses the same layout with header M/2, followed by the terminator.

Parameters:
ADDR_W, 12, SRAM address width
DATA_W, 16, SRAM word width; maximum map width M
TERM_WORD, 16'h00FF, end-of-stream marker

Ports:
clk  in  1  clock
reset_b  in  1  asynchronous active-low reset
pool_run  in  1  start pulse, sampled only in IDLE
pool_busy  out  1  high from the cycle after accepted pool_run until the terminator write has completed
pool_err  out  1  sticky bad-header flag; cleared on the next accepted pool_run
pool_sram_read_address  out  ADDR_W  registered read address
sram_pool_read_data  in  DATA_W  read data, valid one cycle after the address is presented
pool_sram_write_address  out  ADDR_W  registered write address
pool_sram_write_data  out  DATA_W  registered write data
pool_sram_write_enable  out  1  registered write strobe

Behaviour:
- Reset: reset_b is asynchronous, active-low; clk is the clock. All outputs reset to 0, FSM to IDLE, counters to 0.
- FSM states: IDLE, HDR_RD, HDR_CHK, ROW_RD, ROW_FLUSH, TERM_WR, DONE.
- IDLE:
  - On pool_run: read address <- 0, write address <- 0, pool_err <- 0, pool_busy <- 1, go to HDR_RD.
  - pool_run while busy is ignored.
- HDR_RD: wait one cycle for read data; go to HDR_CHK.
- HDR_CHK, header word H:
  - H == TERM_WORD: go to TERM_WR.
  - H[15:5] == 0, H even and 2 <= H <= 16: latch M = H. Write header M/2 at the current write address (wr_en high 1 cycle). Read address +1. Row counter <- 0. Go to ROW_RD.
  - Otherwise: pool_err <- 1, go to TERM_WR.
- ROW_RD:
  - Read address increments every cycle, M reads total.
  - Each even row word is held in a pair register.
  - When the odd row word arrives: o = even | odd (bitwise); pooled bit k = o[2k] | o[2k+1] for k < M/2; upper bits 0.
  - The pooled word is written the cycle after the odd row data is valid, at write address +1 from the previous write.
  - After the M-th read is issued, go to ROW_FLUSH.
- ROW_FLUSH:
  - Complete the last pending write.
  - Read address already points at the next header; go to HDR_RD.
  - Maps follow back-to-back without gaps in either SRAM.
- TERM_WR: write TERM_WORD at the next write address (1 cycle), then go to DONE.
- DONE: pool_busy <- 0, read address <- 0, go to IDLE.
- Throughput: one read per cycle; one write per two reads.
- Latencies:
  - Header data valid to header write: 1 cycle.
  - pool_run to first write: 3 cycles.
- Write enable: never asserted in IDLE, HDR_RD or DONE.
- Write address: increments only after an actual write. Read and write addresses wrap modulo 2^ADDR_W.
- Reset mid-operation: immediate abort; no further writes; pool_busy = 0.

Decomposition:
- Shared package bin_acc_pkg:
  - FSM state encoding (one-hot).
  - TERM_WORD.
  - Legal-header check function.
  - ADDR_W/DATA_W defaults, shared with the conv stage.
- Sub-module pool_row_reduce: combinational, DATA_W-wide. Inputs even row, odd row, M/2; output pooled word. It carries the OR-pair reduction and the masking of bits k >= M/2.

Test Plan:
- M=8 map: row0 = 16'h0081, rows1-7 = 0, then terminator -> writes 0x0004@0, 0x0009@1, 0x0000@2..4, 0x00FF@5; pool_busy falls after the addr 5 write.
- Two maps: M=10 (all rows 16'h03FF), then M=16 (row pairs alternating 16'hAAAA/16'h5555) -> 0x0005@0, 0x001F@1..5, 0x0008@6, 0x00FF@7..14, 0x00FF terminator@15; no gap cycles between maps.
- SRAM[0] = 16'h00FF -> single write 0x00FF@0; pool_err = 0; busy clears within 4 cycles.
- Header 16'h0007 -> pool_err = 1; only write is 0x00FF@0. The next pool_run with valid data clears pool_err.
- pool_run pulsed every cycle during an M=8 run -> identical output to a single pulse; a restart is accepted only after pool_busy = 0.
- reset_b low mid-map (after 3 row reads) -> all outputs 0 immediately; a subsequent run restarts at read address 0 with correct output.
